// File: rtl/frame_scan_reader_pkg.sv
// Shared constants for the frame scan reader: FSM encoding, buffer defaults, counter sizing.
package frame_scan_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int DEF_BUF0_BASE = 0;
  localparam int DEF_BUF1_BASE = 2048;

  function automatic int frame_bytes(input int rows, input int cols);
    return rows * cols;
  endfunction

  // One extra bit so a counter can hold the terminal value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/byte_fwft_fifo.sv
// First-word-fall-through FIFO; head is valid whenever !empty, zero-cycle read latency.
// Push on full is accepted only together with a pop; pop on empty is ignored.
module byte_fwft_fifo
  import frame_scan_reader_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = CW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/frame_scan_reader.sv
// Issues one frame of byte reads per frame_start, credit-limited to the local return FIFO, and
// streams returned pixels with valid/ready; request strobe is combinational, pixels fall through.
module frame_scan_reader
  import frame_scan_reader_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 25,
  parameter int COLS           = 64,
  parameter int ROWS           = 32,
  parameter int BUF0_BASE      = DEF_BUF0_BASE,
  parameter int BUF1_BASE      = DEF_BUF1_BASE,
  parameter int OUT_FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     swap_req,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_wr,
  output logic [7:0]               mem_data_in,
  output logic                     mem_data_in_ready,
  input  logic                     mem_fifo_full,
  input  logic [7:0]               mem_data_out,
  input  logic                     mem_data_out_ready,
  output logic [7:0]               pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     pix_last,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     active_buffer,
  output logic                     overrun,
  output logic                     ret_overflow
);

  localparam int FRAME_BYTES = frame_bytes(ROWS, COLS);
  localparam int CW          = cnt_width(FRAME_BYTES);
  localparam int OW          = cnt_width(OUT_FIFO_DEPTH);

  localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_BYTES - 1);
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BYTES);
  localparam logic [OW:0]   CREDITS   = (OW+1)'(OUT_FIFO_DEPTH);

  logic [1:0]               state;
  logic                     swap_pending;
  logic                     next_buf;
  logic [ADDRESS_WIDTH-1:0] base;
  logic [CW-1:0]            issue_cnt;
  logic [CW-1:0]            ret_cnt;
  logic [CW-1:0]            pop_cnt;
  logic [OW-1:0]            outstanding;
  logic [OW-1:0]            fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [7:0]               fifo_head;
  logic                     credit_ok;
  logic                     accept;
  logic                     ret_fire;
  logic                     ret_drop;
  logic                     push;
  logic                     pop;

  // Every in-flight read already owns a FIFO slot, so returns can never find the FIFO full.
  assign credit_ok         = ({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS;
  assign mem_data_in_ready = (state == ST_ISSUE) && !mem_fifo_full && credit_ok;
  assign accept            = mem_data_in_ready;
  assign mem_address       = base + ADDRESS_WIDTH'(issue_cnt);
  assign mem_wr            = 1'b0;
  assign mem_data_in       = 8'd0;

  assign ret_fire = mem_data_out_ready && (state != ST_IDLE);
  assign pop      = pix_valid && pix_ready;
  assign ret_drop = ret_fire && fifo_full && !pop;
  assign push     = ret_fire && !ret_drop;

  assign pix_valid = !fifo_empty;
  assign pix_data  = fifo_empty ? 8'd0 : fifo_head;
  assign pix_last  = pix_valid && (pop_cnt == LAST_IDX);
  assign busy      = (state != ST_IDLE);
  assign next_buf  = active_buffer ^ swap_pending;

  byte_fwft_fifo #(
    .DEPTH (OUT_FIFO_DEPTH),
    .WIDTH (8)
  ) u_ret_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mem_data_out),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      swap_pending  <= 1'b0;
      active_buffer <= 1'b0;
      base          <= '0;
      issue_cnt     <= '0;
      ret_cnt       <= '0;
      pop_cnt       <= '0;
      outstanding   <= '0;
      overrun       <= 1'b0;
      ret_overflow  <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // A request landing on the same edge as a frame start is kept for the following frame.
      if (swap_req)
        swap_pending <= 1'b1;
      else if (frame_start && state == ST_IDLE)
        swap_pending <= 1'b0;

      if (frame_start && state != ST_IDLE) overrun <= 1'b1;
      if (ret_drop) ret_overflow <= 1'b1;

      if (accept && !ret_fire)      outstanding <= outstanding + OW'(1);
      else if (!accept && ret_fire) outstanding <= outstanding - OW'(1);

      if (accept)   issue_cnt <= issue_cnt + CW'(1);
      if (ret_fire) ret_cnt   <= ret_cnt + CW'(1);
      if (pop)      pop_cnt   <= pop_cnt + CW'(1);

      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state         <= ST_ISSUE;
            active_buffer <= next_buf;
            base          <= next_buf ? ADDRESS_WIDTH'(BUF1_BASE) : ADDRESS_WIDTH'(BUF0_BASE);
            issue_cnt     <= '0;
            ret_cnt       <= '0;
            pop_cnt       <= '0;
          end
        end
        ST_ISSUE: begin
          if (accept && issue_cnt == LAST_IDX) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (ret_cnt == FRAME_CNT && fifo_empty) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scan_reader.sv
// Directed bench for frame_scan_reader: a 2-cycle behavioural RAM plus a frame-level model
// (requests, returns and pops as plain counts) checked against the DUT every cycle.
module tb_frame_scan_reader;

  localparam int FB = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        swap_req;
  logic [24:0] mem_address;
  logic        mem_wr;
  logic [7:0]  mem_data_in;
  logic        mem_data_in_ready;
  logic        mem_fifo_full;
  logic [7:0]  mem_data_out;
  logic        mem_data_out_ready;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;
  logic        frame_done;
  logic        busy;
  logic        active_buffer;
  logic        overrun;
  logic        ret_overflow;

  int errors = 0;
  int checks = 0;

  // Frame-level model
  int n_req, n_pop, n_ret, exp_base, done_cnt, last_cnt;
  bit m_busy, m_issuing, m_done, m_active, m_swap, m_overrun;
  bit c_strobe, c_valid, c_done_next;

  // RAM model state
  bit       ram_acc, pipe_v;
  bit [7:0] ram_addr, pipe_d;

  always #5 clk = ~clk;

  frame_scan_reader dut (
    .clk                (clk),
    .reset              (reset),
    .frame_start        (frame_start),
    .swap_req           (swap_req),
    .mem_address        (mem_address),
    .mem_wr             (mem_wr),
    .mem_data_in        (mem_data_in),
    .mem_data_in_ready  (mem_data_in_ready),
    .mem_fifo_full      (mem_fifo_full),
    .mem_data_out       (mem_data_out),
    .mem_data_out_ready (mem_data_out_ready),
    .pix_data           (pix_data),
    .pix_valid          (pix_valid),
    .pix_ready          (pix_ready),
    .pix_last           (pix_last),
    .frame_done         (frame_done),
    .busy               (busy),
    .active_buffer      (active_buffer),
    .overrun            (overrun),
    .ret_overflow       (ret_overflow)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    n_req = 0; n_pop = 0; n_ret = 0; exp_base = 0;
    m_busy = 0; m_issuing = 0; m_done = 0;
    m_active = 0; m_swap = 0; m_overrun = 0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    if (m_swap) begin
      m_active = !m_active;
      m_swap   = 0;
    end
    exp_base  = m_active ? 2048 : 0;
    n_req     = 0;
    n_pop     = 0;
    n_ret     = 0;
    last_cnt  = 0;
    m_busy    = 1;
    m_issuing = 1;
  endtask

  task automatic wait_done(input int budget);
    int start_cnt;
    start_cnt = done_cnt;
    for (int i = 0; i < budget && done_cnt == start_cnt; i++) step();
    chk("frame_completed", done_cnt - start_cnt, 1);
  endtask

  // Returns addr[7:0] two cycles after a request is accepted.
  initial begin
    mem_data_out_ready = 1'b0;
    mem_data_out       = 8'd0;
    pipe_v             = 0;
    pipe_d             = 8'd0;
    forever begin
      @(negedge clk);
      ram_acc  = mem_data_in_ready;
      ram_addr = mem_address[7:0];
      @(posedge clk);
      #1;
      mem_data_out_ready = pipe_v;
      mem_data_out       = pipe_d;
      pipe_v             = ram_acc;
      pipe_d             = ram_addr;
    end
  end

  // Per-cycle compare against the frame model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        c_strobe    = m_issuing && !mem_fifo_full && (n_req - n_pop < 16);
        c_valid     = n_ret > n_pop;
        c_done_next = m_busy && n_ret == FB && n_pop == FB;

        chk("strobe", mem_data_in_ready, c_strobe);
        if (m_issuing) chk("address", mem_address, exp_base + n_req);
        chk("pix_valid", pix_valid, c_valid);
        if (c_valid) chk("pix_data", pix_data, (exp_base + n_pop) & 255);
        chk("pix_last", pix_last, c_valid && n_pop == FB - 1);
        chk("busy", busy, m_busy);
        chk("frame_done", frame_done, m_done);
        chk("active_buffer", active_buffer, m_active);
        chk("overrun", overrun, m_overrun);
        chk("ret_overflow", ret_overflow, 0);
        chk("mem_wr", mem_wr, 0);
        chk("mem_data_in", mem_data_in, 0);

        if (frame_done) done_cnt++;
        if (pix_valid && pix_ready && pix_last) last_cnt++;
        if (mem_data_in_ready && m_issuing) n_req++;
        if (n_req == FB) m_issuing = 0;
        if (pix_valid && pix_ready) n_pop++;
        if (mem_data_out_ready && m_busy) n_ret++;
        m_done = c_done_next;
        if (c_done_next) m_busy = 0;
      end
    end
  end

  initial begin
    int held;
    reset         = 1'b1;
    frame_start   = 1'b0;
    swap_req      = 1'b0;
    mem_fifo_full = 1'b0;
    pix_ready     = 1'b1;
    done_cnt      = 0;
    last_cnt      = 0;
    model_clear();
    repeat (3) step();

    chk("rst_busy", busy, 0);
    chk("rst_strobe", mem_data_in_ready, 0);
    chk("rst_address", mem_address, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_last", pix_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_active_buffer", active_buffer, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ret_overflow", ret_overflow, 0);
    reset = 1'b0;
    step();

    // Reset mid-ISSUE aborts at once
    start_frame();
    repeat (20) step();
    chk("mid_issue_busy", busy, 1);
    chk("mid_issue_progress", n_req > 0, 1);
    reset = 1'b1;
    model_clear();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_strobe", mem_data_in_ready, 0);
    chk("abort_address", mem_address, 0);
    chk("abort_pix_valid", pix_valid, 0);
    step();
    chk("abort_busy_next", busy, 0);
    chk("abort_pix_data", pix_data, 0);
    reset = 1'b0;
    repeat (5) step();
    chk("post_abort_valid", pix_valid, 0);
    chk("post_abort_busy", busy, 0);

    // Full frame at full rate
    done_cnt = 0;
    start_frame();
    wait_done(6000);
    chk("full_reqs", n_req, 2048);
    chk("full_pops", n_pop, 2048);
    chk("full_last_count", last_cnt, 1);
    chk("full_done_count", done_cnt, 1);
    chk("full_busy_after", busy, 0);

    // Downstream backpressure
    pix_ready = 1'b0;
    start_frame();
    repeat (60) step();
    chk("bp_reqs", n_req, 16);
    chk("bp_strobe", mem_data_in_ready, 0);
    chk("bp_valid", pix_valid, 1);
    chk("bp_head", pix_data, 8'h00);
    pix_ready = 1'b1;
    repeat (4) step();
    chk("bp_resumed", n_req > 16, 1);
    wait_done(6000);
    chk("bp_ret_overflow", ret_overflow, 0);
    chk("bp_pops", n_pop, 2048);

    // Arbiter slot full
    start_frame();
    repeat (30) step();
    mem_fifo_full = 1'b1;
    step();
    held = n_req;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_strobe", mem_data_in_ready, 0);
      chk("stall_address", mem_address, held);
    end
    mem_fifo_full = 1'b0;
    #1;
    chk("release_strobe", mem_data_in_ready, 1);
    chk("release_address", mem_address, held);
    wait_done(6000);
    chk("stall_reqs", n_req, 2048);

    // Swap requested mid-frame takes effect at the next frame
    start_frame();
    repeat (100) step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    m_swap   = 1;
    chk("swap_mid_active", active_buffer, 0);
    wait_done(6000);
    chk("swap_frame_active", active_buffer, 0);
    start_frame();
    chk("swap_active", active_buffer, 1);
    chk("swap_first_addr", mem_address, 2048);

    // frame_start during DRAIN
    for (int i = 0; i < 6000 && n_req < FB; i++) step();
    chk("reached_drain", n_req, 2048);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    m_overrun   = 1;
    chk("overrun_set", overrun, 1);
    wait_done(6000);
    chk("overrun_pops", n_pop, 2048);
    repeat (10) step();
    chk("overrun_no_restart", busy, 0);
    chk("overrun_sticky", overrun, 1);
    chk("overrun_active", active_buffer, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_scan_reader.md
Name: frame_scan_reader

Overview:
- Sequences frame-buffer reads for the LED matrix scan-out path and occupies one requester slot on the shared byte-wide RAM arbiter.
- On each frame_start it issues ROWS*COLS read requests from the active buffer, credit-limited so returned bytes can never overflow its local output FIFO.
- Streams the returned pixels downstream with valid/ready.
- Manages double-buffer swap at frame boundaries.

Parameters:
- ADDRESS_WIDTH, 25, RAM address width; matches the arbiter.
- COLS, 64, pixels per row.
- ROWS, 32, rows per frame. FRAME_BYTES = COLS*ROWS.
- BUF0_BASE, 0, byte address of buffer 0.
- BUF1_BASE, 2048, byte address of buffer 1.
- OUT_FIFO_DEPTH, 16, local return FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that starts a frame read.
- swap_req  in  1  one-cycle pulse requesting a buffer swap at the next frame start.
- mem_address  out  ADDRESS_WIDTH  read address to the arbiter slot.
- mem_wr  out  1  tied 0.
- mem_data_in  out  8  tied 0.
- mem_data_in_ready  out  1  request strobe.
- mem_fifo_full  in  1  arbiter slot FIFO full.
- mem_data_out  in  8  RAM read data.
- mem_data_out_ready  in  1  this slot's read-return strobe.
- pix_data  out  8  pixel byte.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accepts.
- pix_last  out  1  high with the final byte of a frame.
- frame_done  out  1  one-cycle pulse when a frame has fully drained.
- busy  out  1  high whenever state != IDLE.
- active_buffer  out  1  buffer currently or last read.
- overrun  out  1  sticky flag: frame_start arrived while busy.
- ret_overflow  out  1  sticky flag: a return arrived while the FIFO was full.

Behaviour:
- Reset:
  - State = IDLE.
  - All counters and FIFO pointers cleared.
  - All outputs 0, including active_buffer, swap_pending, overrun, ret_overflow and frame_done.
- States:
  - IDLE -> ISSUE on frame_start.
  - ISSUE -> DRAIN when issue_cnt reaches FRAME_BYTES.
  - DRAIN -> IDLE when ret_cnt == FRAME_BYTES and the FIFO is empty. frame_done pulses for one cycle on this transition.
- Frame start (in IDLE):
  - If swap_pending, toggle active_buffer and clear swap_pending.
  - base is latched from active_buffer as it stands after any toggle.
  - issue_cnt and ret_cnt are cleared.
- swap_req in any state sets swap_pending. It never affects the frame in progress.
- frame_start outside IDLE is ignored and sets overrun.
- Issue (combinational from registered state):
  - credit_ok = outstanding + fifo_count < OUT_FIFO_DEPTH.
  - mem_data_in_ready = (state==ISSUE) & !mem_fifo_full & credit_ok.
  - mem_address = base + issue_cnt.
  - A request counts as accepted in the same cycle; on the next posedge issue_cnt++ and outstanding++.
  - While mem_fifo_full or !credit_ok, the strobe stays low and mem_address holds.
- Return:
  - On mem_data_out_ready in ISSUE or DRAIN, push mem_data_out, ret_cnt++, outstanding--.
  - Simultaneous accept and return leaves outstanding unchanged.
  - A return in IDLE is dropped and not counted.
  - A return with the FIFO full (cannot happen with correct credit) is dropped and sets ret_overflow.
- Output:
  - pix_valid = !fifo_empty; pix_data = FIFO head (first-word fall-through).
  - Pop on pix_valid & pix_ready. Simultaneous push and pop on a full FIFO is legal.
  - pix_last is high when the head byte is byte FRAME_BYTES-1. Track this with a pop counter, cleared at frame start.
- Widths:
  - issue_cnt, ret_cnt and pop counter are $clog2(FRAME_BYTES)+1 bits.
  - outstanding and fifo_count are $clog2(OUT_FIFO_DEPTH)+1 bits.
  - The address add is zero-extended to ADDRESS_WIDTH; wrap-around is not permitted by parameter choice.
- Reset asserted mid-frame aborts immediately to reset values. The RAM read latency is unconstrained; credits handle any latency.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ISSUE, DRAIN);
  - FRAME_BYTES and counter-width helpers;
  - BUF0_BASE / BUF1_BASE defaults.
- One sub-module, byte_fwft_fifo (DEPTH, WIDTH=8): push/pop/full/empty/count, asynchronous active-high reset.

Test Plan:
- Reset: assert reset mid-ISSUE -> every output 0 next cycle, busy=0, mem_data_in_ready=0.
- Full frame: behavioural RAM returns addr[7:0] with 2-cycle latency, pix_ready=1, frame_start -> 2048 requests at addresses 0..2047, pix_data sequence 0x00..0xFF repeated, pix_last only on byte 2048, a single frame_done, busy falls in the same cycle.
- Backpressure: pix_ready=0 -> exactly 16 accepted requests then strobe stays low; raise pix_ready -> issuing resumes; ret_overflow stays 0.
- Arbiter full: mem_fifo_full=1 for 10 cycles -> no strobe, mem_address stable; release -> the next address follows with no skip or duplicate.
- Swap: swap_req mid-frame -> frame continues from base 0; next frame_start -> first address 2048, active_buffer=1.
- Overrun: frame_start during DRAIN -> overrun=1 (sticky), current frame completes unchanged, no new frame starts.
